// File: rtl/trace_plotter.sv
// Waveform frame plotter: after the screen wipe, reads one sample per column, flips/clamps it to
// screen y and strobes plot. Optional feature macro: TRACE_CONNECT_EN (vertical line-connect).
module trace_plotter #(
    parameter int          X_PIXELS = 160,
    parameter int          Y_PIXELS = 120,
    parameter int          ADDR_W   = 10,
    parameter int          SAMP_W   = 9,
    parameter logic [2:0]  COLOUR   = 3'b010
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              wipe_busy,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [SAMP_W-1:0] ram_q,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic [2:0]        colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WIPE = 3'd1,
        S_FETCH     = 3'd2,
        S_LATCH     = 3'd3,
        S_DRAW      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // Sample 0 is the bottom row; anything at or above the top row pins to row 0.
    function automatic logic [6:0] flip_clamp(input logic [SAMP_W-1:0] samp);
        logic [SAMP_W-1:0] ymax;
        ymax = SAMP_W'(Y_PIXELS - 1);
        if (samp >= ymax) begin
            return 7'd0;
        end else begin
            return 7'(ymax - samp);
        end
    endfunction

    state_t      state_r, state_n;
    logic [7:0]  col_r, col_n;
    logic [6:0]  ycur_r, ycur_n;
    logic [6:0]  ysamp_s;
    logic        last_col_s;
`ifdef TRACE_CONNECT_EN
    logic [6:0]  yprev_r, yprev_n;
    logic [6:0]  ytgt_r, ytgt_n;
`endif

    logic [ADDR_W-1:0] ram_addr_r;
    logic [7:0]        x_r;
    logic [6:0]        y_r;
    logic [2:0]        colour_r;
    logic              plot_r;
    logic              busy_r;
    logic              done_r;

    assign ysamp_s    = flip_clamp(ram_q);
    assign last_col_s = (col_r == 8'(X_PIXELS - 1));

    // Next-state, column and y-cursor decisions.
    always_comb begin
        state_n = state_r;
        col_n   = col_r;
        ycur_n  = ycur_r;
`ifdef TRACE_CONNECT_EN
        yprev_n = yprev_r;
        ytgt_n  = ytgt_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_n = S_WAIT_WIPE;
                    col_n   = 8'd0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_WAIT_WIPE: begin
                if (wipe_busy) begin
                    state_n = S_WAIT_WIPE;
                end else begin
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                if (wipe_busy) begin
                    state_n = S_WAIT_WIPE;
                    col_n   = 8'd0;
                end else begin
                    state_n = S_LATCH;
                end
            end
            S_LATCH: begin
                if (wipe_busy) begin
                    state_n = S_WAIT_WIPE;
                    col_n   = 8'd0;
                end else begin
                    state_n = S_DRAW;
`ifdef TRACE_CONNECT_EN
                    // The segment starts one step past the previous column's end point.
                    ytgt_n = ysamp_s;
                    if ((col_r == 8'd0) || (yprev_r == ysamp_s)) begin
                        ycur_n = ysamp_s;
                    end else if (yprev_r > ysamp_s) begin
                        ycur_n = yprev_r - 7'd1;
                    end else begin
                        ycur_n = yprev_r + 7'd1;
                    end
                    if (col_r == 8'd0) begin
                        yprev_n = ysamp_s;
                    end else begin
                        yprev_n = yprev_r;
                    end
`else
                    ycur_n = ysamp_s;
`endif
                end
            end
            S_DRAW: begin
                if (wipe_busy) begin
                    state_n = S_WAIT_WIPE;
                    col_n   = 8'd0;
`ifdef TRACE_CONNECT_EN
                end else if (ycur_r != ytgt_r) begin
                    state_n = S_DRAW;
                    if (ycur_r > ytgt_r) begin
                        ycur_n = ycur_r - 7'd1;
                    end else begin
                        ycur_n = ycur_r + 7'd1;
                    end
`endif
                end else if (last_col_s) begin
                    state_n = S_DONE;
`ifdef TRACE_CONNECT_EN
                    yprev_n = ytgt_r;
`endif
                end else begin
                    state_n = S_FETCH;
                    col_n   = col_r + 8'd1;
`ifdef TRACE_CONNECT_EN
                    yprev_n = ytgt_r;
`endif
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                col_n   = 8'd0;
            end
        endcase
    end

    // State registers; outputs are registered from the next-state values so they align with the state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            col_r      <= 8'd0;
            ycur_r     <= 7'd0;
`ifdef TRACE_CONNECT_EN
            yprev_r    <= 7'd0;
            ytgt_r     <= 7'd0;
`endif
            ram_addr_r <= {ADDR_W{1'b0}};
            x_r        <= 8'd0;
            y_r        <= 7'd0;
            colour_r   <= 3'd0;
            plot_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            col_r      <= col_n;
            ycur_r     <= ycur_n;
`ifdef TRACE_CONNECT_EN
            yprev_r    <= yprev_n;
            ytgt_r     <= ytgt_n;
`endif
            ram_addr_r <= ADDR_W'(col_n);
            x_r        <= col_n;
            y_r        <= ycur_n;
            colour_r   <= (state_n == S_DRAW) ? COLOUR : 3'd0;
            plot_r     <= (state_n == S_DRAW);
            busy_r     <= (state_n != S_IDLE);
            done_r     <= (state_n == S_DONE);
        end
    end

    assign ram_addr = ram_addr_r;
    assign x        = x_r;
    assign y        = y_r;
    assign colour   = colour_r;
    assign plot     = plot_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_trace_plotter.sv
// Directed bench for trace_plotter: RAM model, plot scoreboard, latency and control checks.
module tb_trace_plotter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       wipe_busy = 1'b0;
    logic [9:0] ram_addr;
    logic [8:0] ram_q = 9'd0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
    } pix_t;

    pix_t       exp_q[$];
    logic [8:0] mem [0:1023];
    int         checks = 0;
    int         errors = 0;
    int         done_count = 0;

    always #5 clock = ~clock;

    trace_plotter dut (
        .clock(clock), .reset(reset), .start(start), .wipe_busy(wipe_busy),
        .ram_addr(ram_addr), .ram_q(ram_q), .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always @(posedge clock) ram_q <= mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every plot strobe must match the oldest expected pixel.
    always @(negedge clock) begin
        if (done === 1'b1) done_count++;
        if (plot === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_plot: observed x=%0d y=%0d expected no plot", x, y);
            end
            if (exp_q.size() != 0) begin
                pix_t e;
                e = exp_q.pop_front();
                check("plot_x", 32'(x), 32'(e.px));
                check("plot_y", 32'(y), 32'(e.py));
                check("plot_colour", 32'(colour), 32'd2);
            end
        end
    end

    task automatic fill_mem(input logic [8:0] v);
        for (int i = 0; i < 1024; i++) mem[i] = v;
    endtask

    task automatic push_pix(input int px, input int py);
        pix_t p;
        p.px = 8'(px);
        p.py = 7'(py);
        exp_q.push_back(p);
    endtask

    task automatic start_frame();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clock);
            #1;
            cycles++;
            if (done === 1'b1) break;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    int cyc;
    int samp_t [5] = '{0, 60, 119, 200, 511};
    int yexp_t [5] = '{119, 59, 0, 0, 0};

    initial begin
        fill_mem(9'd0);

        // 1: reset dominates start
        reset = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        @(negedge clock);
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);

`ifndef TRACE_CONNECT_EN
        // 2: flat line and frame latency
        for (int c = 0; c < 160; c++) push_pix(c, 119);
        start_frame();
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(700, cyc);
        check("frame_latency", 32'(cyc + 1), 32'd482);
        check("flat_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);

        // 3: flip and clamp
        for (int i = 0; i < 5; i++) mem[i] = 9'(samp_t[i]);
        for (int c = 0; c < 160; c++) push_pix(c, (c < 5) ? yexp_t[c] : 119);
        start_frame();
        wait_done(700, cyc);
        check("clamp_queue_empty", 32'(exp_q.size()), 32'd0);
        fill_mem(9'd0);

        // 4a: no plot during a long wipe, first plot 3 cycles after it ends
        @(negedge clock);
        wipe_busy = 1'b1;
        start_frame();
        repeat (19200) @(negedge clock);
        check("wipe_busy_held", 32'(busy), 32'd1);
        for (int c = 0; c < 160; c++) push_pix(c, 119);
        wipe_busy = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
            if (plot === 1'b1) break;
        end
        check("first_plot_latency", 32'(cyc), 32'd3);
        check("first_plot_x", 32'(x), 32'd0);
        wait_done(700, cyc);
        check("wipe_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4b: wipe pulse at x=80 aborts and restarts, one done
        repeat (3) @(negedge clock);
        done_count = 0;
        for (int c = 0; c < 80; c++) push_pix(c, 119);
        start_frame();
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clock);
            #1;
            cyc++;
            if (plot === 1'b1 && x == 8'd79) break;
        end
        check("reach_x79", 32'(x), 32'd79);
        @(negedge clock);
        @(negedge clock);
        wipe_busy = 1'b1;
        repeat (4) begin
            @(posedge clock);
            #1;
            check("abort_plot_low", 32'(plot), 32'd0);
        end
        check("abort_addr", 32'(ram_addr), 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int c = 0; c < 160; c++) push_pix(c, 119);
        @(negedge clock);
        wipe_busy = 1'b0;
        wait_done(700, cyc);
        repeat (5) @(negedge clock);
        check("abort_done_count", 32'(done_count), 32'd1);
        check("abort_queue_drained", 32'(exp_q.size()), 32'd0);

        // 5: start while busy and start with done are dropped
        done_count = 0;
        for (int c = 0; c < 160; c++) push_pix(c, 119);
        start_frame();
        repeat (50) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(700, cyc);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        check("start_at_done_dropped", 32'(busy), 32'd0);
        repeat (500) @(negedge clock);
        check("busy_start_done_count", 32'(done_count), 32'd1);
        check("busy_start_idle", 32'(busy), 32'd0);
`else
        // 6: line-connect segments
        fill_mem(9'd10);
        mem[0] = 9'd0;
        push_pix(0, 119);
        for (int yy = 118; yy >= 109; yy--) push_pix(1, yy);
        for (int c = 2; c < 160; c++) push_pix(c, 109);
        start_frame();
        wait_done(2000, cyc);
        check("connect_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
        check("connect_busy_after", 32'(busy), 32'd0);
`endif

        // reset beats start again, from idle
        @(negedge clock);
        reset = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock);
        #1;
        check("reset_start_busy", 32'(busy), 32'd0);
        check("reset_start_plot", 32'(plot), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
